// File: rtl/dpd_mem3_core_if.sv
// dpd_mem3_core_if: sample, coefficient, output and basis bundle for dpd_mem3_core.
interface dpd_mem3_core_if #(
    parameter int W  = 20,
    parameter int NB = 15
);
    logic signed [W-1:0] sig_in_i, sig_in_q, sig_out_i, sig_out_q;
    logic [NB*W-1:0] coeff_i, coeff_q, yy_i, yy_q;
    modport master (
        output sig_in_i, sig_in_q, coeff_i, coeff_q,
        input sig_out_i, sig_out_q, yy_i, yy_q
    );
    modport slave (
        input sig_in_i, sig_in_q, coeff_i, coeff_q,
        output sig_out_i, sig_out_q, yy_i, yy_q
    );
endinterface

// File: rtl/dpd_mem3_core.sv
// dpd_mem3_core: 3-tap, 5-order complex memory-polynomial filter.
// Also exports the 15 aligned basis samples for adaptation.
module dpd_mem3_core #(
    parameter int W  = 20,
    parameter int NT = 3,
    parameter int NK = 5
) (
    input logic clk,
    input logic reset_b,
    dpd_mem3_core_if.slave bus
);
    localparam int NB = NT * NK;
    localparam int PW = 2 * W + 1;
    localparam int AW = 46;
    localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    typedef logic signed [W-1:0] s_t;

    function automatic s_t sat(input logic signed [AW-1:0] v);
        return (v > AW'(SMAX)) ? SMAX : (v < AW'(SMIN)) ? SMIN : v[W-1:0];
    endfunction

    function automatic logic [W-1:0] magn(input s_t i, input s_t q);
        logic [W-1:0] ai, aq, mx, mn;
        ai = i[W-1] ? -i : i;
        aq = q[W-1] ? -q : q;
        mx = (ai > aq) ? ai : aq;
        mn = (ai > aq) ? aq : ai;
        return mx + (mn >> 2) + (mn >> 3);
    endfunction

    // One rail of b_k = sat((b_{k-1} * mag) >>> 19)
    function automatic s_t scale(input s_t r, input logic [W-1:0] m);
        logic signed [PW-1:0] p;
        p = PW'(r) * $signed(PW'(m));
        return sat(AW'(p >>> (W - 1)));
    endfunction

    s_t xi_q, xq_q, xi_d, xq_d;
    s_t bi_q [1:NK-1][NK];
    s_t bq_q [1:NK-1][NK];
    s_t bi_d [1:NK-1][NK];
    s_t bq_d [1:NK-1][NK];
    logic [W-1:0] mag_q [1:NK-1];
    logic [W-1:0] mag_d [1:NK-1];
    s_t di_q [NT][NK];
    s_t dq_q [NT][NK];
    s_t di_d [NT][NK];
    s_t dq_d [NT][NK];
    s_t yi [NB];
    s_t yq [NB];
    logic signed [PW-1:0] pi_q [NB];
    logic signed [PW-1:0] pq_q [NB];
    logic signed [PW-1:0] pi_d [NB];
    logic signed [PW-1:0] pq_d [NB];
    logic signed [AW-1:0] acc_i_q, acc_q_q, acc_i_d, acc_q_d;
    s_t oi_q, oq_q, oi_d, oq_d;
    logic signed [PW-1:0] ce, qe, ye, ze;

    always_comb begin
        xi_d = bus.sig_in_i;
        xq_d = bus.sig_in_q;
        bi_d = '{default: '0};
        bq_d = '{default: '0};
        bi_d[1][0] = xi_q;
        bq_d[1][0] = xq_q;
        mag_d[1] = magn(xi_q, xq_q);
        for (int s = 2; s < NK; s++) mag_d[s] = mag_q[s-1];
        for (int s = 1; s < NK - 1; s++) begin
            bi_d[s+1] = bi_q[s];
            bq_d[s+1] = bq_q[s];
            bi_d[s+1][s] = scale(bi_q[s][s-1], mag_q[s]);
            bq_d[s+1][s] = scale(bq_q[s][s-1], mag_q[s]);
        end
        // Tap m=0 of the delay line is the last order stage, so every b_k lines up there
        di_d[0] = bi_q[NK-1];
        dq_d[0] = bq_q[NK-1];
        di_d[0][NK-1] = scale(bi_q[NK-1][NK-2], mag_q[NK-1]);
        dq_d[0][NK-1] = scale(bq_q[NK-1][NK-2], mag_q[NK-1]);
        for (int m = 1; m < NT; m++) begin
            di_d[m] = di_q[m-1];
            dq_d[m] = dq_q[m-1];
        end
        bus.yy_i = '0;
        bus.yy_q = '0;
        ce = '0;
        qe = '0;
        ye = '0;
        ze = '0;
        for (int j = 0; j < NB; j++) begin
            yi[j] = di_q[j % NT][j / NT];
            yq[j] = dq_q[j % NT][j / NT];
            bus.yy_i[j*W +: W] = yi[j];
            bus.yy_q[j*W +: W] = yq[j];
            ce = PW'($signed(bus.coeff_i[j*W +: W]));
            qe = PW'($signed(bus.coeff_q[j*W +: W]));
            ye = PW'(yi[j]);
            ze = PW'(yq[j]);
            pi_d[j] = ce * ye - qe * ze;
            pq_d[j] = ce * ze + qe * ye;
        end
        acc_i_d = '0;
        acc_q_d = '0;
        for (int j = 0; j < NB; j++) begin
            acc_i_d = acc_i_d + AW'(pi_q[j]);
            acc_q_d = acc_q_d + AW'(pq_q[j]);
        end
        oi_d = sat(acc_i_q >>> (W - 1));
        oq_d = sat(acc_q_q >>> (W - 1));
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            xi_q <= '0;
            xq_q <= '0;
            bi_q <= '{default: '0};
            bq_q <= '{default: '0};
            mag_q <= '{default: '0};
            di_q <= '{default: '0};
            dq_q <= '{default: '0};
            pi_q <= '{default: '0};
            pq_q <= '{default: '0};
            acc_i_q <= '0;
            acc_q_q <= '0;
            oi_q <= '0;
            oq_q <= '0;
        end else begin
            xi_q <= xi_d;
            xq_q <= xq_d;
            bi_q <= bi_d;
            bq_q <= bq_d;
            mag_q <= mag_d;
            di_q <= di_d;
            dq_q <= dq_d;
            pi_q <= pi_d;
            pq_q <= pq_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            oi_q <= oi_d;
            oq_q <= oq_d;
        end
    end

    assign bus.sig_out_i = oi_q;
    assign bus.sig_out_q = oq_q;
endmodule

// File: tb/tb_dpd_mem3_core.sv
// tb_dpd_mem3_core: directed vectors, impulse sequences and a randomized run checked
// against a sample-history model of the memory polynomial.
module tb_dpd_mem3_core;
    localparam int W = 20;
    localparam int NB = 15;

    logic clk = 1'b0;
    logic reset_b = 1'b1;
    always #5 clk = ~clk;

    logic signed [W-1:0] xi, xq;
    logic [NB*W-1:0] ci, cq;

    dpd_mem3_core_if #(.W(W), .NB(NB)) bus ();
    assign bus.sig_in_i = xi;
    assign bus.sig_in_q = xq;
    assign bus.coeff_i = ci;
    assign bus.coeff_q = cq;

    dpd_mem3_core #(.W(W), .NT(3), .NK(5)) dut (.clk(clk), .reset_b(reset_b), .bus(bus));

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkv(input string nm, input logic [NB*W-1:0] act, input logic [NB*W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint yyv(input logic [NB*W-1:0] v, input int j);
        logic signed [W-1:0] s;
        s = v[j*W +: W];
        return s;
    endfunction

    // Reference model: recompute every basis value from the raw sample history
    function automatic longint fl(input longint v);
        return v >>> 19;
    endfunction

    function automatic longint clip(input longint v);
        return v > 524287 ? 524287 : (v < -524288 ? -524288 : v);
    endfunction

    function automatic void basis(input longint i, input longint q, input int k,
                                  output longint bi, output longint bq);
        longint a, b, mx, mn, m;
        a = i < 0 ? -i : i;
        b = q < 0 ? -q : q;
        mx = a > b ? a : b;
        mn = a > b ? b : a;
        m = mx + mn / 4 + mn / 8;
        bi = i;
        bq = q;
        for (int n = 0; n < k; n++) begin
            bi = clip(fl(bi * m));
            bq = clip(fl(bq * m));
        end
    endfunction

    int e = 0;
    int last_rst = 0;
    longint hx_i [16];
    longint hx_q [16];
    logic [NB*W-1:0] hc_i [16];
    logic [NB*W-1:0] hc_q [16];
    longint hy_i [16][NB];
    longint hy_q [16][NB];
    longint exp_oi = 0, exp_oq = 0;
    logic [NB*W-1:0] exp_yi = '0, exp_yq = '0;

    always @(posedge clk) begin
        longint bi, bq, si, sq, cr, cm;
        int src;
        e++;
        if (reset_b) last_rst = e;
        hx_i[e % 16] = xi;
        hx_q[e % 16] = xq;
        hc_i[e % 16] = ci;
        hc_q[e % 16] = cq;
        for (int j = 0; j < NB; j++) begin
            src = e - 5 - j % 3;
            if (src <= last_rst) begin
                bi = 0;
                bq = 0;
            end else basis(hx_i[src % 16], hx_q[src % 16], j / 3, bi, bq);
            hy_i[e % 16][j] = bi;
            hy_q[e % 16][j] = bq;
            exp_yi[j*W +: W] = W'(bi);
            exp_yq[j*W +: W] = W'(bq);
        end
        if (e - 2 <= last_rst) begin
            exp_oi = 0;
            exp_oq = 0;
        end else begin
            si = 0;
            sq = 0;
            for (int j = 0; j < NB; j++) begin
                cr = yyv(hc_i[(e - 2) % 16], j);
                cm = yyv(hc_q[(e - 2) % 16], j);
                si += cr * hy_i[(e - 3) % 16][j] - cm * hy_q[(e - 3) % 16][j];
                sq += cr * hy_q[(e - 3) % 16][j] + cm * hy_i[(e - 3) % 16][j];
            end
            exp_oi = clip(fl(si));
            exp_oq = clip(fl(sq));
        end
    end

    always @(negedge clk) begin
        if (e > 0) begin
            chk("model_out_i", bus.sig_out_i, exp_oi);
            chk("model_out_q", bus.sig_out_q, exp_oq);
            chkv("model_yy_i", bus.yy_i, exp_yi);
            chkv("model_yy_q", bus.yy_q, exp_yq);
        end
    end

    function automatic logic [W-1:0] rnd(input int maxsh);
        logic signed [W-1:0] v;
        v = W'($urandom);
        return v >>> $urandom_range(0, maxsh);
    endfunction

    task automatic rand_coeffs();
        for (int j = 0; j < NB; j++) begin
            ci[j*W +: W] = ($urandom_range(0, 2) == 0) ? '0 : rnd(12);
            cq[j*W +: W] = ($urandom_range(0, 2) == 0) ? '0 : rnd(12);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_out_i"}, bus.sig_out_i, 0);
        chk({nm, "_out_q"}, bus.sig_out_q, 0);
        chkv({nm, "_yy_i"}, bus.yy_i, '0);
        chkv({nm, "_yy_q"}, bus.yy_q, '0);
    endtask

    task automatic impulse(input int j, input int lo, input int ly);
        ci = '0;
        cq = '0;
        ci[j*W +: W] = 20'sd524287;
        xi = '0;
        xq = '0;
        repeat (12) @(negedge clk);
        xi = 20'sd100000;
        xq = -20'sd100000;
        @(negedge clk);
        xi = '0;
        xq = '0;
        for (int k = 0; k <= 12; k++) begin
            chk($sformatf("imp%0d_out_i_k%0d", j, k), bus.sig_out_i, k == lo ? 99999 : 0);
            chk($sformatf("imp%0d_out_q_k%0d", j, k), bus.sig_out_q, k == lo ? -100000 : 0);
            chk($sformatf("imp%0d_yy_i_k%0d", j, k), yyv(bus.yy_i, j), k == ly ? 100000 : 0);
            chk($sformatf("imp%0d_yy_q_k%0d", j, k), yyv(bus.yy_q, j), k == ly ? -100000 : 0);
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [14:0] mask;
        int cr, cm, xr, xm, yj, eoi, eoq, eyi, eyq;
    } vec_t;
    vec_t tv [12];

    initial begin
        tv[0]  = '{15'h0001, 0, 524287, 100000, 0, 0, 0, 99999, 100000, 0};
        tv[1]  = '{15'h0001, 0, 524287, 0, 100000, 0, -100000, 0, 0, 100000};
        tv[2]  = '{15'h0008, 524287, 0, 262144, 0, 3, 131071, 0, 131072, 0};
        tv[3]  = '{15'h0040, 524287, 0, 262144, 0, 6, 65535, 0, 65536, 0};
        tv[4]  = '{15'h0007, 524287, 0, 524287, 0, 0, 524287, 0, 524287, 0};
        tv[5]  = '{15'h0007, 524287, 0, -524288, 0, 2, -524288, 0, -524288, 0};
        tv[6]  = '{15'h0008, 524287, 0, 524287, 524287, 3, 524286, 524286, 524287, 524287};
        tv[7]  = '{15'h0040, 524287, 0, 524287, 524287, 6, 524286, 524286, 524287, 524287};
        tv[8]  = '{15'h0000, 0, 0, 300000, -200000, 0, 0, 0, 300000, -200000};
        tv[9]  = '{15'h0002, 524287, 0, 100000, -100000, 1, 99999, -100000, 100000, -100000};
        tv[10] = '{15'h4000, 524287, 0, 262144, 0, 14, 16383, 0, 16384, 0};
        tv[11] = '{15'h0001, 262144, 262144, 262144, 262144, 0, 0, 262144, 262144, 262144};

        xi = rnd(0);
        xq = rnd(0);
        rand_coeffs();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk_zero("reset");
            xi = rnd(0);
            xq = rnd(0);
            rand_coeffs();
        end
        reset_b = 1'b0;
        xi = '0;
        xq = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk_zero("release");
        end

        impulse(0, 8, 5);
        impulse(1, 9, 6);
        impulse(2, 10, 7);

        for (int t = 0; t < 12; t++) begin
            for (int j = 0; j < NB; j++) begin
                ci[j*W +: W] = tv[t].mask[j] ? W'(tv[t].cr) : '0;
                cq[j*W +: W] = tv[t].mask[j] ? W'(tv[t].cm) : '0;
            end
            xi = W'(tv[t].xr);
            xq = W'(tv[t].xm);
            repeat (14) @(negedge clk);
            chk($sformatf("vec%0d_out_i", t), bus.sig_out_i, tv[t].eoi);
            chk($sformatf("vec%0d_out_q", t), bus.sig_out_q, tv[t].eoq);
            chk($sformatf("vec%0d_yy_i", t), yyv(bus.yy_i, tv[t].yj), tv[t].eyi);
            chk($sformatf("vec%0d_yy_q", t), yyv(bus.yy_q, tv[t].yj), tv[t].eyq);
        end

        rand_coeffs();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            reset_b = ($urandom_range(0, 79) == 0);
            xi = rnd($urandom_range(0, 1) ? 0 : 4);
            xq = rnd($urandom_range(0, 1) ? 0 : 4);
            if ($urandom_range(0, 7) == 0) rand_coeffs();
        end
        reset_b = 1'b0;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
